hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Central hazard/scheduling controller for the 5-stage pipeline.
- Generates stall enables for the fetch PC and the fetch/decode register, plus the clear for the decode/execute register (bubble insertion).
- Generates forwarding selects for decode (branch compare) and execute (ALU operands).
- Sequences the multi-cycle HI/LO multiply/divide unit with a busy counter, so MFHI/MFLO and back-to-back MULT/DIV wait for completion.

Parameters:
- MULT_LATENCY, 4, cycles a MULT/MULTU occupies HI/LO after leaving execute (≥1).
- DIV_LATENCY, 32, cycles a DIV/DIVU occupies HI/LO after leaving execute (≥ MULT_LATENCY).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Rs_decode  in  5  source register Rs of the instruction in decode
- Rt_decode  in  5  source register Rt of the instruction in decode
- Rs_execute  in  5  source register Rs of the instruction in execute
- Rt_execute  in  5  source register Rt of the instruction in execute
- write_register_execute  in  5  destination register, execute stage
- write_register_memory  in  5  destination register, memory stage
- write_register_writeback  in  5  destination register, writeback stage
- register_write_execute  in  1  execute-stage instruction writes the register file
- register_write_memory  in  1  memory-stage instruction writes the register file
- register_write_writeback  in  1  writeback-stage instruction writes the register file
- memory_to_register_execute  in  1  execute-stage instruction is a load
- memory_to_register_memory  in  1  memory-stage instruction is a load
- branch_decode  in  1  decode instruction compares registers (BEQ/BNE/JR)
- hi_lo_access_decode  in  1  decode instruction reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO/MULT/DIV)
- mult_div_start_execute  in  1  MULT/DIV in execute this cycle
- divide_execute  in  1  qualifies the start as a divide
- stall_fetch  out  1  hold the PC
- stall_decode  out  1  hold the fetch/decode register
- flush_execute  out  1  clear the decode/execute register
- forward_A_decode  out  1  Rs comparator takes the memory-stage ALU result
- forward_B_decode  out  1  Rt comparator takes the memory-stage ALU result
- forward_A_execute  out  2  ALU A select
- forward_B_execute  out  2  ALU B select
- hi_lo_busy  out  1  multiply/divide in progress

Behaviour:
- Forward encoding (execute): 00 = register file, 01 = writeback result, 10 = memory ALU result.
  - Memory stage has priority over writeback when both match.
  - Register 0 is never forwarded.
  - A match requires the corresponding register_write_* to be high.
- Decode forward:
  - Asserted when register_write_memory is high, write_register_memory ≠ 0 and equals Rs_decode/Rt_decode.
  - Suppressed when memory_to_register_memory is high; the branch stall covers that case.
- load_stall:
  - Condition: memory_to_register_execute & register_write_execute & write_register_execute ≠ 0.
  - And write_register_execute equals Rs_decode or Rt_decode.
- branch_stall: branch_decode and either of:
  - register_write_execute with write_register_execute ≠ 0 matching Rs_decode/Rt_decode, or
  - memory_to_register_memory with write_register_memory ≠ 0 matching.
- hi_lo_stall: hi_lo_access_decode & hi_lo_busy.
- Stall outputs: stall_fetch = stall_decode = flush_execute = load_stall | branch_stall | hi_lo_stall. All are combinational, zero-latency.
- Busy FSM: states IDLE, BUSY; down-counter count, width $clog2(DIV_LATENCY+1).
  - IDLE: mult_div_start_execute at edge T → BUSY, count = (divide_execute ? DIV_LATENCY : MULT_LATENCY) − 1.
  - BUSY: count decrements each edge. At count = 0 with no start → IDLE.
  - Start while BUSY (not expected because decode stalls): reload the counter and stay BUSY.
  - Start at the same edge as count reaches 0: reload the counter and stay BUSY.
  - hi_lo_busy = (state == BUSY), registered. It is high for exactly LATENCY cycles after the start cycle.
- Reset: asynchronous. State = IDLE, count = 0, hi_lo_busy = 0.
  - With all inputs 0, every stall/flush/forward output reads 0.
  - Reset mid-operation aborts the busy window immediately, with no residual stall.
- Simultaneous load_stall and hi_lo_stall: single combined stall, no double-count.
  - The counter keeps decrementing during stalls.

Decomposition:
- Package hazard_pkg holds:
  - Forward-select localparams FWD_REGFILE = 2'b00, FWD_WRITEBACK = 2'b01, FWD_MEMORY = 2'b10.
  - Busy state enum {IDLE, BUSY}.
- Sub-module hi_lo_busy_counter holds the FSM plus counter. Its inputs are start, divide, clk and reset; its output is busy.
- Forward and stall logic stay in the top level.

Test Plan:
- Reset asserted mid-BUSY (divide started 5 cycles earlier) → hi_lo_busy drops asynchronously; after release, hi_lo_access_decode=1 gives stall=0.
- Forwarding priority: write_register_memory = write_register_writeback = 5, Rs_execute=5, both register_write=1 → forward_A_execute=10. Then Rs_execute=0 → 00.
- Load-use: memory_to_register_execute=1, write_register_execute=8, Rt_decode=8 → stall_fetch=stall_decode=flush_execute=1 for one cycle; with write_register_execute=0 → no stall.
- Branch hazard: branch_decode=1, Rs_decode=3, register_write_execute=1, write_register_execute=3 → stall. Next cycle the same match moves to the memory stage (register_write_memory=1, memory_to_register_memory=0), giving no stall and forward_A_decode=1.
- MULT timing: start with divide=0 at cycle 0 → hi_lo_busy=1 in cycles 1–4, 0 in cycle 5. MFHI in decode is stalled in cycles 1–4 and released in cycle 5.
- DIV back-to-back: start with divide=1 at cycle 0 and again at cycle 32 (the cycle count reaches 0) → busy stays high continuously through cycle 64 and drops at 65.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forward-select codes and busy-state type for the hazard controller
package hazard_pkg;

   localparam logic [1:0] FWD_REGFILE   = 2'b00;
   localparam logic [1:0] FWD_WRITEBACK = 2'b01;
   localparam logic [1:0] FWD_MEMORY    = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } busy_state_t;

endpackage

// File: rtl/hi_lo_busy_counter.sv
// rtl/hi_lo_busy_counter.sv - occupancy tracker for the multi-cycle HI/LO multiply/divide unit
module hi_lo_busy_counter
   import hazard_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic divide,
   output logic busy
);

   localparam int CW = $clog2(DIV_LATENCY + 1);
   localparam logic [CW-1:0] MULT_RELOAD = CW'(MULT_LATENCY - 1);
   localparam logic [CW-1:0] DIV_RELOAD  = CW'(DIV_LATENCY - 1);

   busy_state_t   state_q;
   logic [CW-1:0] count_q;

   // A start always reloads, even on the edge where count reaches 0, so
   // back-to-back operations keep the busy window unbroken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else if (start) begin
         state_q <= BUSY;
         count_q <= divide ? DIV_RELOAD : MULT_RELOAD;
      end else if (state_q == BUSY) begin
         if (count_q == '0) begin
            state_q <= IDLE;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall, bubble and forwarding control with HI/LO busy sequencing
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_decode,
   input  logic [4:0] Rt_decode,
   input  logic [4:0] Rs_execute,
   input  logic [4:0] Rt_execute,
   input  logic [4:0] write_register_execute,
   input  logic [4:0] write_register_memory,
   input  logic [4:0] write_register_writeback,
   input  logic       register_write_execute,
   input  logic       register_write_memory,
   input  logic       register_write_writeback,
   input  logic       memory_to_register_execute,
   input  logic       memory_to_register_memory,
   input  logic       branch_decode,
   input  logic       hi_lo_access_decode,
   input  logic       mult_div_start_execute,
   input  logic       divide_execute,
   output logic       stall_fetch,
   output logic       stall_decode,
   output logic       flush_execute,
   output logic       forward_A_decode,
   output logic       forward_B_decode,
   output logic [1:0] forward_A_execute,
   output logic [1:0] forward_B_execute,
   output logic       hi_lo_busy
);

   logic mem_writes, wb_writes, ex_writes;
   logic ex_hits_decode, mem_hits_decode;
   logic load_stall, branch_stall, hi_lo_stall;

   assign mem_writes = register_write_memory    && (write_register_memory    != 5'd0);
   assign wb_writes  = register_write_writeback && (write_register_writeback != 5'd0);
   assign ex_writes  = register_write_execute   && (write_register_execute   != 5'd0);

   always_comb begin
      forward_A_execute = FWD_REGFILE;
      if (mem_writes && (write_register_memory == Rs_execute)) begin
         forward_A_execute = FWD_MEMORY;
      end else if (wb_writes && (write_register_writeback == Rs_execute)) begin
         forward_A_execute = FWD_WRITEBACK;
      end
   end

   always_comb begin
      forward_B_execute = FWD_REGFILE;
      if (mem_writes && (write_register_memory == Rt_execute)) begin
         forward_B_execute = FWD_MEMORY;
      end else if (wb_writes && (write_register_writeback == Rt_execute)) begin
         forward_B_execute = FWD_WRITEBACK;
      end
   end

   // A load in memory has no ALU result yet; the branch stall holds decode instead.
   assign forward_A_decode = mem_writes && !memory_to_register_memory
                             && (write_register_memory == Rs_decode);
   assign forward_B_decode = mem_writes && !memory_to_register_memory
                             && (write_register_memory == Rt_decode);

   assign ex_hits_decode  = (write_register_execute == Rs_decode)
                            || (write_register_execute == Rt_decode);
   assign mem_hits_decode = (write_register_memory == Rs_decode)
                            || (write_register_memory == Rt_decode);

   assign load_stall   = memory_to_register_execute && ex_writes && ex_hits_decode;
   assign branch_stall = branch_decode
                         && ((ex_writes && ex_hits_decode)
                             || (memory_to_register_memory && (write_register_memory != 5'd0)
                                 && mem_hits_decode));
   assign hi_lo_stall  = hi_lo_access_decode && hi_lo_busy;

   assign stall_fetch   = load_stall || branch_stall || hi_lo_stall;
   assign stall_decode  = stall_fetch;
   assign flush_execute = stall_fetch;

   hi_lo_busy_counter #(
      .MULT_LATENCY(MULT_LATENCY),
      .DIV_LATENCY (DIV_LATENCY)
   ) u_busy (
      .clk   (clk),
      .reset (reset),
      .start (mult_div_start_execute),
      .divide(divide_execute),
      .busy  (hi_lo_busy)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_decode, Rt_decode, Rs_execute, Rt_execute;
   logic [4:0] write_register_execute, write_register_memory, write_register_writeback;
   logic       register_write_execute, register_write_memory, register_write_writeback;
   logic       memory_to_register_execute, memory_to_register_memory;
   logic       branch_decode, hi_lo_access_decode, mult_div_start_execute, divide_execute;
   logic       stall_fetch, stall_decode, flush_execute;
   logic       forward_A_decode, forward_B_decode;
   logic [1:0] forward_A_execute, forward_B_execute;
   logic       hi_lo_busy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_controller #(.MULT_LATENCY(4), .DIV_LATENCY(32)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .Rs_decode                 (Rs_decode),
      .Rt_decode                 (Rt_decode),
      .Rs_execute                (Rs_execute),
      .Rt_execute                (Rt_execute),
      .write_register_execute    (write_register_execute),
      .write_register_memory     (write_register_memory),
      .write_register_writeback  (write_register_writeback),
      .register_write_execute    (register_write_execute),
      .register_write_memory     (register_write_memory),
      .register_write_writeback  (register_write_writeback),
      .memory_to_register_execute(memory_to_register_execute),
      .memory_to_register_memory (memory_to_register_memory),
      .branch_decode             (branch_decode),
      .hi_lo_access_decode       (hi_lo_access_decode),
      .mult_div_start_execute    (mult_div_start_execute),
      .divide_execute            (divide_execute),
      .stall_fetch               (stall_fetch),
      .stall_decode              (stall_decode),
      .flush_execute             (flush_execute),
      .forward_A_decode          (forward_A_decode),
      .forward_B_decode          (forward_B_decode),
      .forward_A_execute         (forward_A_execute),
      .forward_B_execute         (forward_B_execute),
      .hi_lo_busy                (hi_lo_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All three stall outputs must agree with the single expected value.
   task automatic check_stall(input string tag, input logic exp);
      check({tag, ".stall_fetch"},   {31'd0, stall_fetch},   {31'd0, exp});
      check({tag, ".stall_decode"},  {31'd0, stall_decode},  {31'd0, exp});
      check({tag, ".flush_execute"}, {31'd0, flush_execute}, {31'd0, exp});
   endtask

   task automatic clear_inputs();
      Rs_decode = 0; Rt_decode = 0; Rs_execute = 0; Rt_execute = 0;
      write_register_execute = 0; write_register_memory = 0; write_register_writeback = 0;
      register_write_execute = 0; register_write_memory = 0; register_write_writeback = 0;
      memory_to_register_execute = 0; memory_to_register_memory = 0;
      branch_decode = 0; hi_lo_access_decode = 0;
      mult_div_start_execute = 0; divide_execute = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      #2;
      check_stall("reset", 1'b0);
      check("reset.fwdA_dec", {31'd0, forward_A_decode}, 32'd0);
      check("reset.fwdB_dec", {31'd0, forward_B_decode}, 32'd0);
      check("reset.fwdA_ex",  {30'd0, forward_A_execute}, 32'd0);
      check("reset.fwdB_ex",  {30'd0, forward_B_execute}, 32'd0);
      check("reset.busy",     {31'd0, hi_lo_busy}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("post_reset.busy", {31'd0, hi_lo_busy}, 32'd0);

      // Forwarding priority
      write_register_memory = 5; write_register_writeback = 5;
      register_write_memory = 1; register_write_writeback = 1;
      Rs_execute = 5; Rt_execute = 5;
      #1;
      check("fwd.mem_prio_A", {30'd0, forward_A_execute}, 32'd2);
      check("fwd.mem_prio_B", {30'd0, forward_B_execute}, 32'd2);
      register_write_memory = 0;
      #1;
      check("fwd.wb_A", {30'd0, forward_A_execute}, 32'd1);
      Rs_execute = 0;
      register_write_memory = 1;
      #1;
      check("fwd.rs0_A", {30'd0, forward_A_execute}, 32'd0);
      check("fwd.rt5_B", {30'd0, forward_B_execute}, 32'd2);
      write_register_memory = 0; write_register_writeback = 0; Rt_execute = 0;
      #1;
      check("fwd.reg0_B", {30'd0, forward_B_execute}, 32'd0);
      register_write_memory = 1; register_write_writeback = 0;
      write_register_memory = 7; write_register_writeback = 7; Rs_execute = 7;
      #1;
      register_write_memory = 0; register_write_writeback = 1;
      #1;
      check("fwd.wb_only_A", {30'd0, forward_A_execute}, 32'd1);
      register_write_writeback = 0;
      #1;
      check("fwd.no_write_A", {30'd0, forward_A_execute}, 32'd0);
      clear_inputs();

      // Load-use
      memory_to_register_execute = 1; register_write_execute = 1;
      write_register_execute = 8; Rt_decode = 8;
      #1;
      check_stall("load_use", 1'b1);
      write_register_execute = 0;
      #1;
      check_stall("load_use_r0", 1'b0);
      write_register_execute = 8; register_write_execute = 0;
      #1;
      check_stall("load_no_regwrite", 1'b0);
      tick();
      clear_inputs();
      #1;
      check_stall("load_cleared", 1'b0);

      // Branch hazard, then the same producer one stage later
      branch_decode = 1; Rs_decode = 3;
      register_write_execute = 1; write_register_execute = 3;
      #1;
      check_stall("branch_ex", 1'b1);
      check("branch_ex.fwdA_dec", {31'd0, forward_A_decode}, 32'd0);
      tick();
      register_write_execute = 0; write_register_execute = 0;
      register_write_memory = 1; write_register_memory = 3;
      #1;
      check_stall("branch_mem_alu", 1'b0);
      check("branch_mem.fwdA_dec", {31'd0, forward_A_decode}, 32'd1);
      check("branch_mem.fwdB_dec", {31'd0, forward_B_decode}, 32'd0);
      memory_to_register_memory = 1;
      #1;
      check_stall("branch_mem_load", 1'b1);
      check("branch_load.fwdA_dec", {31'd0, forward_A_decode}, 32'd0);
      branch_decode = 0;
      #1;
      check_stall("nobranch_mem_load", 1'b0);
      clear_inputs();
      Rt_decode = 9; register_write_memory = 1; write_register_memory = 9;
      #1;
      check("fwdB_dec", {31'd0, forward_B_decode}, 32'd1);
      clear_inputs();
      tick();

      // MULT timing: start in cycle 0, MFHI waiting in decode throughout
      mult_div_start_execute = 1; divide_execute = 0; hi_lo_access_decode = 1;
      #1;
      check("mult.c0_busy", {31'd0, hi_lo_busy}, 32'd0);
      check_stall("mult.c0", 1'b0);
      tick();
      mult_div_start_execute = 0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            memory_to_register_execute = 1; register_write_execute = 1;
            write_register_execute = 4; Rs_decode = 4;
         end else begin
            memory_to_register_execute = 0; register_write_execute = 0;
            write_register_execute = 0; Rs_decode = 0;
         end
         #1;
         check($sformatf("mult.c%0d_busy", c), {31'd0, hi_lo_busy}, 32'd1);
         check_stall($sformatf("mult.c%0d", c), 1'b1);
         tick();
      end
      clear_inputs();
      hi_lo_access_decode = 1;
      #1;
      check("mult.c5_busy", {31'd0, hi_lo_busy}, 32'd0);
      check_stall("mult.c5", 1'b0);
      clear_inputs();
      tick();

      // DIV back-to-back: second start in the cycle the count reaches 0
      mult_div_start_execute = 1; divide_execute = 1;
      tick();
      mult_div_start_execute = 0; divide_execute = 0;
      for (int c = 1; c <= 64; c++) begin
         if (c == 32) begin
            mult_div_start_execute = 1; divide_execute = 1;
         end else begin
            mult_div_start_execute = 0; divide_execute = 0;
         end
         #1;
         check($sformatf("div.c%0d_busy", c), {31'd0, hi_lo_busy}, 32'd1);
         tick();
      end
      clear_inputs();
      #1;
      check("div.c65_busy", {31'd0, hi_lo_busy}, 32'd0);
      tick();

      // Reset mid-divide
      mult_div_start_execute = 1; divide_execute = 1;
      tick();
      clear_inputs();
      for (int c = 1; c <= 5; c++) tick();
      hi_lo_access_decode = 1;
      #1;
      check("rst_mid.before_busy", {31'd0, hi_lo_busy}, 32'd1);
      check_stall("rst_mid.before", 1'b1);
      reset = 1'b1;
      #1;
      check("rst_mid.async_busy", {31'd0, hi_lo_busy}, 32'd0);
      check_stall("rst_mid.async", 1'b0);
      tick();
      reset = 1'b0;
      #1;
      check_stall("rst_mid.released", 1'b0);
      tick();
      check("rst_mid.after_busy", {31'd0, hi_lo_busy}, 32'd0);
      check_stall("rst_mid.after", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
